rtc_hms_core: RTL

- Parametrised time-of-day core, successor to the free-running seconds counter.
- Divides `clock` down to a 1 Hz tick using a parameterised prescaler, and keeps BCD seconds, minutes and hours (00:00:00–23:59:59).
- Supports a run/hold control, a validated BCD set port, 12/24-hour display mode and a minute-resolution alarm.
- Feeds the seven-segment display path and the top-level status pins.

---
 rtl/rtc_hms_core.sv | 133 +++++++++++++
 1 files changed

// File: rtl/rtc_hms_core.sv
// Time-of-day core: prescaled 1 Hz tick, BCD hh:mm:ss, validated set port,
// 12/24 h display mapping and a minute-resolution alarm.
module rtc_hms_core #(
  parameter int TICK_DIV = 65536,
  parameter bit ALARM_EN = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       run,
  input  logic       mode_12h,
  input  logic       set_valid,
  input  logic [1:0] set_field,
  input  logic [7:0] set_data,
  input  logic [7:0] alarm_hour,
  input  logic [7:0] alarm_min,
  input  logic       alarm_arm,
  output logic [7:0] sec_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] hour_bcd,
  output logic       pm,
  output logic       tick_1hz,
  output logic       set_err,
  output logic       alarm_hit
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

  logic [CW-1:0] presc_reg;
  logic [7:0]    sec_reg, min_reg, hour_reg;
  logic          tick_reg, err_reg, hit_reg;

  logic          tick_cycle, set_ok, alarm_match;
  logic [7:0]    set_limit;
  logic          sec_wrap, min_wrap;
  logic [7:0]    sec_next, min_next, hour_next;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                return {v[7:4], v[3:0] + 4'd1};
  endfunction

  assign tick_cycle = run && (presc_reg == CNT_MAX);

  // Nibble checks first, so the plain magnitude compare below is a BCD compare.
  always_comb begin
    set_limit = (set_field == 2'd2) ? 8'h23 : 8'h59;
    set_ok    = set_valid && (set_field != 2'd3) &&
                (set_data[7:4] <= 4'd9) && (set_data[3:0] <= 4'd9) &&
                (set_data <= set_limit);
  end

  always_comb begin
    sec_wrap  = (sec_reg == 8'h59);
    min_wrap  = (min_reg == 8'h59);
    sec_next  = sec_wrap ? 8'h00 : bcd_inc(sec_reg);
    min_next  = min_reg;
    hour_next = hour_reg;
    if (sec_wrap) begin
      min_next = min_wrap ? 8'h00 : bcd_inc(min_reg);
      if (min_wrap) hour_next = (hour_reg == 8'h23) ? 8'h00 : bcd_inc(hour_reg);
    end
  end

  generate
    if (ALARM_EN) begin : g_alarm
      logic alarm_ok;
      assign alarm_ok = (alarm_hour[7:4] <= 4'd9) && (alarm_hour[3:0] <= 4'd9) &&
                        (alarm_min[7:4] <= 4'd9) && (alarm_min[3:0] <= 4'd9) &&
                        (alarm_hour <= 8'h23) && (alarm_min <= 8'h59);
      assign alarm_match = alarm_arm && alarm_ok && (sec_next == 8'h00) &&
                           (min_next == alarm_min) && (hour_next == alarm_hour);
    end else begin : g_no_alarm
      assign alarm_match = 1'b0;
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (!reset) begin
      presc_reg <= '0;
      sec_reg   <= 8'h00;
      min_reg   <= 8'h00;
      hour_reg  <= 8'h00;
      tick_reg  <= 1'b0;
      err_reg   <= 1'b0;
      hit_reg   <= 1'b0;
    end else begin
      tick_reg <= 1'b0;
      hit_reg  <= 1'b0;
      err_reg  <= set_valid && !set_ok;
      // An accepted write wins over a coincident tick and restarts the second.
      if (set_ok) begin
        presc_reg <= '0;
        case (set_field)
          2'd0:    sec_reg  <= set_data;
          2'd1:    min_reg  <= set_data;
          default: hour_reg <= set_data;
        endcase
      end else if (run) begin
        if (tick_cycle) begin
          presc_reg <= '0;
          sec_reg   <= sec_next;
          min_reg   <= min_next;
          hour_reg  <= hour_next;
          tick_reg  <= 1'b1;
          hit_reg   <= alarm_match;
        end else begin
          presc_reg <= presc_reg + CW'(1);
        end
      end
    end
  end

  logic [4:0] hour_bin, hour_12;

  always_comb begin
    hour_bin = 5'(hour_reg[7:4]) * 5'd10 + 5'(hour_reg[3:0]);
    if (hour_bin == 5'd0)      hour_12 = 5'd12;
    else if (hour_bin > 5'd12) hour_12 = hour_bin - 5'd12;
    else                       hour_12 = hour_bin;
    if (!mode_12h)             hour_bcd = hour_reg;
    else if (hour_12 >= 5'd10) hour_bcd = {4'd1, 4'(hour_12 - 5'd10)};
    else                       hour_bcd = {4'd0, hour_12[3:0]};
    pm = mode_12h && (hour_bin >= 5'd12);
  end

  assign sec_bcd   = sec_reg;
  assign min_bcd   = min_reg;
  assign tick_1hz  = tick_reg;
  assign set_err   = err_reg;
  assign alarm_hit = hit_reg;

endmodule
